// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART byte serializer among several
// byte producers, locking the grant for a whole frame.
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 grant_active,
  output logic [ID_W-1:0]      grant_id,
  output logic                 timeout_err
);

  localparam logic [1:0] S_ARB       = 2'd0;
  localparam logic [1:0] S_LOAD      = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            grant_active_q, grant_active_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            timeout_err_q, timeout_err_d;
  logic [15:0]     idle_cnt_q, idle_cnt_d;
  logic            last_q, last_d;

  logic            own_valid;
  logic            own_last;
  logic [7:0]      own_data;
  logic            arb_found;
  logic [ID_W-1:0] arb_winner;
  logic [ID_W-1:0] next_ptr;
  logic [15:0]     idle_inc;

  // Select the current owner's request signals.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = 8'h00;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[8*i +: 8];
      end
    end
  end

  // First valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    logic [ID_W-1:0] cand;
    arb_found  = 1'b0;
    arb_winner = rr_ptr_q;
    cand       = rr_ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!arb_found && req_valid[cand]) begin
        arb_found  = 1'b1;
        arb_winner = cand;
      end
    end
  end

  assign next_ptr = ID_W'((32'(grant_id_q) + 32'd1) % NUM_REQ);
  assign idle_inc = idle_cnt_q + 16'd1;

  // Ready is asserted only to the owner while waiting for its next byte.
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_q == S_LOAD) && (grant_id_q == ID_W'(i));
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_active_d = grant_active_q;
    grant_id_d     = grant_id_q;
    tx_start_d     = 1'b0;
    tx_data_d      = tx_data_q;
    timeout_err_d  = 1'b0;
    idle_cnt_d     = idle_cnt_q;
    last_d         = last_q;
    case (state_q)
      S_ARB: begin
        if (arb_found) begin
          grant_id_d     = arb_winner;
          grant_active_d = 1'b1;
          idle_cnt_d     = 16'd0;
          state_d        = S_LOAD;
        end
      end
      S_LOAD: begin
        if (own_valid) begin
          tx_data_d  = own_data;
          tx_start_d = 1'b1;
          last_d     = own_last;
          idle_cnt_d = 16'd0;
          state_d    = S_WAIT_BUSY;
        end else if (idle_inc == TIMEOUT) begin
          timeout_err_d  = 1'b1;
          grant_active_d = 1'b0;
          rr_ptr_d       = next_ptr;
          idle_cnt_d     = 16'd0;
          state_d        = S_ARB;
        end else begin
          idle_cnt_d = idle_inc;
        end
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            grant_active_d = 1'b0;
            rr_ptr_d       = next_ptr;
            state_d        = S_ARB;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: begin
        grant_active_d = 1'b0;
        state_d        = S_ARB;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_ARB;
      rr_ptr_q       <= '0;
      grant_active_q <= 1'b0;
      grant_id_q     <= '0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= 8'h00;
      timeout_err_q  <= 1'b0;
      idle_cnt_q     <= 16'd0;
      last_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_active_q <= grant_active_d;
      grant_id_q     <= grant_id_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
      timeout_err_q  <= timeout_err_d;
      idle_cnt_q     <= idle_cnt_d;
      last_q         <= last_d;
    end
  end

  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;
  assign grant_active = grant_active_q;
  assign grant_id     = grant_id_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: requester queues, a busy-flag serializer
// model, and a frame-level reference model checked every cycle.
module tb_uart_tx_scheduler;

  localparam int          NR  = 4;
  localparam int          IDW = 2;
  localparam logic [15:0] TO  = 16'd10;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [NR-1:0] req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic          grant_active;
  logic [IDW-1:0] grant_id;
  logic          timeout_err;

  uart_tx_scheduler #(.NUM_REQ(NR), .ID_W(IDW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .grant_active(grant_active), .grant_id(grant_id),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester byte queues: bit 8 marks the last byte of a frame.
  logic [8:0] q[NR][$];
  bit         pop_pend[NR];

  // Present queue heads; retire a head one cycle after it was accepted.
  always @(negedge clock) begin
    for (int i = 0; i < NR; i++) begin
      if (!reset_n) pop_pend[i] = 1'b0;
      else if (pop_pend[i]) begin
        if (q[i].size() > 0) void'(q[i].pop_front());
        pop_pend[i] = 1'b0;
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (reset_n && q[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = q[i][0][7:0];
        req_last[i]        = q[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
    for (int i = 0; i < NR; i++) pop_pend[i] = reset_n && req_valid[i] && req_ready[i];
  end

  // Serializer: busy rises one cycle after start and stays up busy_len cycles.
  int busy_len   = 3;
  bit force_busy = 1'b0;
  int ser_cnt    = 0;
  bit ser_pend   = 1'b0;
  always @(negedge clock) begin
    if (!reset_n) begin
      tx_busy = 1'b0; ser_cnt = 0; ser_pend = 1'b0;
    end else if (force_busy) begin
      tx_busy = 1'b1; ser_cnt = 0; ser_pend = 1'b0;
    end else if (ser_cnt > 0) begin
      ser_cnt--;
      tx_busy = (ser_cnt != 0);
    end else if (ser_pend) begin
      tx_busy = 1'b1; ser_cnt = busy_len; ser_pend = 1'b0;
    end else begin
      tx_busy = 1'b0;
    end
    if (reset_n && tx_start && !force_busy) ser_pend = 1'b1;
  end

  // Reference model: who owns the transmitter and what it is waiting for.
  bit       m_active, m_accept, m_seen_busy, m_last, e_start, e_terr;
  int       m_owner, m_prio, m_idle;
  logic [7:0] e_data;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 0; m_accept = 0; m_seen_busy = 0; m_last = 0;
      e_start = 0; e_terr = 0; m_owner = 0; m_prio = 0; m_idle = 0; e_data = 8'h00;
    end else begin
      e_start = 0; e_terr = 0;
      if (!m_active) begin
        bit found;
        found = 0;
        for (int k = 0; k < NR; k++) begin
          int c;
          c = (m_prio + k) % NR;
          if (!found && req_valid[c]) begin
            found = 1; m_active = 1; m_owner = c; m_accept = 1; m_idle = 0;
          end
        end
      end else if (m_accept) begin
        if (req_valid[m_owner]) begin
          e_start = 1; e_data = req_data[8*m_owner +: 8]; m_last = req_last[m_owner];
          m_accept = 0; m_seen_busy = 0; m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle == int'(TO)) begin
            e_terr = 1; m_active = 0; m_accept = 0; m_idle = 0; m_prio = (m_owner + 1) % NR;
          end
        end
      end else if (!m_seen_busy) begin
        if (tx_busy) m_seen_busy = 1;
      end else if (!tx_busy) begin
        if (m_last) begin
          m_active = 0; m_prio = (m_owner + 1) % NR;
        end else m_accept = 1;
      end
    end
  end

  // Observation logs for the directed literal checks.
  int glog[$];
  int tlog[$];
  int terr_cnt = 0;
  int ready3_cnt = 0;
  bit ga_prev = 0;

  // Compare DUT against the model every cycle, and log events.
  always @(negedge clock) begin
    logic [NR-1:0] exp_rdy;
    exp_rdy = (m_active && m_accept) ? NR'(1 << m_owner) : '0;
    chk("req_ready",    32'(req_ready),    32'(exp_rdy));
    chk("tx_start",     32'(tx_start),     32'(e_start));
    chk("tx_data",      32'(tx_data),      32'(e_data));
    chk("grant_active", 32'(grant_active), 32'(m_active));
    chk("grant_id",     32'(grant_id),     32'(m_owner));
    chk("timeout_err",  32'(timeout_err),  32'(e_terr));
    if (reset_n) begin
      if (grant_active && !ga_prev) glog.push_back(int'(grant_id));
      ga_prev = grant_active;
      if (tx_start) tlog.push_back(int'(grant_id) * 256 + int'(tx_data));
      if (timeout_err) terr_cnt++;
      if (req_ready[3]) ready3_cnt++;
    end else ga_prev = 0;
  end

  task automatic flush_all();
    for (int i = 0; i < NR; i++) q[i].delete();
    glog.delete(); tlog.delete(); terr_cnt = 0; ready3_cnt = 0;
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1;
    reset_n = 1'b0;
    flush_all();
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
  endtask

  task automatic wait_idle(input int maxc);
    int  c;
    bit  done;
    c = 0; done = 0;
    while (!done && c < maxc) begin
      @(posedge clock); #1; c++;
      done = !grant_active && !tx_busy && (q[0].size() + q[1].size() + q[2].size() + q[3].size() == 0);
    end
    chk("wait_idle_bound", 32'(done), 32'd1);
  endtask

  task automatic wait_grant(input int maxc);
    int c;
    c = 0;
    while (!grant_active && c < maxc) begin
      @(posedge clock); #1; c++;
    end
    chk("wait_grant_bound", 32'(grant_active), 32'd1);
  endtask

  task automatic chk_list(input string name, input int act[$], input int exp[$]);
    chk({name, "_len"}, 32'(act.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < act.size(); i++) chk(name, 32'(act[i]), 32'(exp[i]));
  endtask

  initial begin
    #1;
    chk("rst_grant_active", 32'(grant_active), 32'd0);
    chk("rst_tx_data",      32'(tx_data),      32'h00);
    chk("rst_grant_id",     32'(grant_id),     32'd0);
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;

    // Single two-byte frame from requester 2 with a realistic byte time.
    busy_len = 2170;
    @(posedge clock); #1;
    q[2].push_back(9'h0A5); q[2].push_back(9'h13C);
    wait_idle(6000);
    chk_list("single_tx", tlog, '{2*256+8'hA5, 2*256+8'h3C});
    chk_list("single_grant", glog, '{2});
    chk("single_grant_id_hold", 32'(grant_id), 32'd2);

    // Round robin with one-byte frames from 0, 1, 3.
    busy_len = 3;
    pulse_reset();
    @(posedge clock); #1;
    q[0].push_back(9'h1A0); q[0].push_back(9'h1A1);
    q[1].push_back(9'h1B0); q[1].push_back(9'h1B1);
    q[3].push_back(9'h1D0); q[3].push_back(9'h1D1);
    wait_idle(400);
    chk_list("rr_grant", glog, '{0, 1, 3, 0, 1, 3});
    chk_list("rr_tx", tlog, '{8'hA0, 256+8'hB0, 768+8'hD0, 8'hA1, 256+8'hB1, 768+8'hD1});

    // Frame lock: requester 1 keeps the grant for all four bytes.
    pulse_reset();
    @(posedge clock); #1;
    q[1].push_back(9'h011); q[1].push_back(9'h022); q[1].push_back(9'h033); q[1].push_back(9'h144);
    wait_grant(20);
    q[0].push_back(9'h10F);
    wait_idle(400);
    chk_list("lock_tx", tlog, '{256+8'h11, 256+8'h22, 256+8'h33, 256+8'h44, 8'h0F});
    chk_list("lock_grant", glog, '{1, 0});

    // Timeout: requester 3 stalls after one non-last byte.
    pulse_reset();
    @(posedge clock); #1;
    q[3].push_back(9'h077);
    wait_grant(20);
    q[0].push_back(9'h15A);
    wait_idle(400);
    chk("to_err_count", 32'(terr_cnt), 32'd1);
    chk("to_ready3_cycles", 32'(ready3_cnt), 32'd11);
    chk_list("to_grant", glog, '{3, 0});
    chk_list("to_tx", tlog, '{768+8'h77, 8'h5A});

    // Asynchronous reset in the middle of a three-byte frame.
    busy_len = 20;
    pulse_reset();
    @(posedge clock); #1;
    q[2].push_back(9'h0C1); q[2].push_back(9'h0C2); q[2].push_back(9'h1C3);
    begin
      int c;
      c = 0;
      while (!tx_busy && c < 50) begin @(posedge clock); #1; c++; end
      chk("mid_busy_bound", 32'(tx_busy), 32'd1);
    end
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    chk("async_grant_active", 32'(grant_active), 32'd0);
    chk("async_grant_id",     32'(grant_id),     32'd0);
    chk("async_tx_data",      32'(tx_data),      32'h00);
    chk("async_req_ready",    32'(req_ready),    32'd0);
    flush_all();
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock); #1;
    busy_len = 3;
    q[0].push_back(9'h1D0); q[2].push_back(9'h1D2);
    wait_idle(200);
    chk_list("post_rst_grant", glog, '{0, 2});

    // Busy already high when the byte is accepted.
    pulse_reset();
    @(posedge clock); #1;
    force_busy = 1'b1;
    q[1].push_back(9'h099); q[1].push_back(9'h198);
    repeat (15) @(posedge clock);
    #1;
    chk("busyhi_starts", 32'(tlog.size()), 32'd1);
    chk("busyhi_no_ready", 32'(req_ready), 32'd0);
    force_busy = 1'b0;
    wait_idle(200);
    chk_list("busyhi_tx", tlog, '{256+8'h99, 256+8'h98});

    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
